// File: rtl/key_bounce_if.sv
// Command and key-line bundle for the key bounce generator.
interface key_bounce_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_key;
  logic       cmd_press;
  logic [3:0] key_out;
  logic       done;

  modport master (
    output cmd_valid, cmd_key, cmd_press,
    input  cmd_ready, key_out, done
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_press,
    output cmd_ready, key_out, done
  );
endinterface

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing active-low key: toggles, then settles and pulses done.
// Define KEY_BOUNCE_LFSR_EN for pseudo-random glitch lengths.
module key_bounce_gen #(
  parameter int BOUNCE_TICKS = 16,
  parameter int GLITCH_MAX   = 4,
  parameter int SETTLE_TICKS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  key_bounce_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  localparam logic [15:0] BT = 16'(BOUNCE_TICKS);
  localparam logic [15:0] ST = 16'(SETTLE_TICKS);

  state_t      state;
  logic [3:0]  key_q;
  logic        ready_q;
  logic        done_q;
  logic [1:0]  sel;
  logic        tgt;
  logic [15:0] bcnt;
  logic [15:0] scnt;
  logic [7:0]  gcnt;
  logic [7:0]  g_load;
  logic        tog;

  assign bus.key_out   = key_q;
  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;

  // A toggle happens on the accept edge and on each in-window glitch expiry
  always_comb begin
    tog = 1'b0;
    if (state == IDLE && bus.cmd_valid &&
        key_q[bus.cmd_key] == bus.cmd_press && BT != 16'd0)
      tog = 1'b1;
    else if (state == BOUNCE && bcnt != 16'd1 && gcnt == 8'd1)
      tog = 1'b1;
  end

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr;
  logic        fb;

  assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign g_load = 8'(32'(lfsr[7:0]) % GLITCH_MAX) + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else if (tog)
      lfsr <= {lfsr[14:0], fb};
  end
`else
  assign g_load = 8'(GLITCH_MAX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= 4'b1111;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sel     <= 2'd0;
      tgt     <= 1'b1;
      bcnt    <= 16'd0;
      scnt    <= 16'd0;
      gcnt    <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sel     <= bus.cmd_key;
            tgt     <= ~bus.cmd_press;
            ready_q <= 1'b0;
            if (key_q[bus.cmd_key] == ~bus.cmd_press) begin
              state  <= SETTLE;
              scnt   <= ST;
              done_q <= (ST == 16'd1);
            end else if (BT == 16'd0) begin
              key_q[bus.cmd_key] <= ~bus.cmd_press;
              state  <= SETTLE;
              scnt   <= ST;
              done_q <= (ST == 16'd1);
            end else begin
              key_q[bus.cmd_key] <= ~key_q[bus.cmd_key];
              state <= BOUNCE;
              bcnt  <= BT;
              gcnt  <= g_load;
            end
          end
        end
        BOUNCE: begin
          if (bcnt == 16'd1) begin
            key_q[sel] <= tgt;
            state  <= SETTLE;
            bcnt   <= 16'd0;
            gcnt   <= 8'd0;
            scnt   <= ST;
            done_q <= (ST == 16'd1);
          end else begin
            bcnt <= bcnt - 16'd1;
            if (tog) begin
              key_q[sel] <= ~key_q[sel];
              gcnt <= g_load;
            end else if (gcnt != 8'd0) begin
              gcnt <= gcnt - 8'd1;
            end
          end
        end
        SETTLE: begin
          if (scnt <= 16'd1) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            scnt    <= 16'd0;
          end else begin
            scnt   <= scnt - 16'd1;
            done_q <= (scnt == 16'd2);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed checks of key_bounce_gen at default parameters.
// Build with KEY_BOUNCE_LFSR_EN to check the pseudo-random glitch model.
module tb_key_bounce_gen;

  localparam int BT = 16;
  localparam int GM = 4;
  localparam int ST = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  key_bounce_if bus ();

  key_bounce_gen #(
    .BOUNCE_TICKS (BT),
    .GLITCH_MAX   (GM),
    .SETTLE_TICKS (ST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          nchk = 0;
  int          nerr = 0;
  logic [3:0]  exp_keys;
  logic [15:0] mlfsr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic send(input int k, input bit p);
    @(negedge clk);
    check("ready_pre", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_key   = 2'(k);
    bus.cmd_press = p;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge (cycle T+1).
  task automatic watch(input int k, input bit tgt,
                       input int inj, input int inj_key,
                       input int abort_at);
    int   tg[$];
    int   obs[$];
    bit   start;
    bit   direct;
    bit   lvl;
    bit   prev;
    int   last;
    logic [3:0] want;
    start  = exp_keys[k];
    direct = (start == tgt);
    if (!direct) begin
`ifdef KEY_BOUNCE_LFSR_EN
      int t;
      int g;
      t = 1;
      while (t <= BT) begin
        tg.push_back(t);
        g = (int'(mlfsr[7:0]) % GM) + 1;
        mlfsr = {mlfsr[14:0],
                 mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
        t += g;
      end
`else
      tg = '{1, 5, 9, 13};
`endif
    end
    last = direct ? ST + 1 : BT + ST + 1;
    prev = start;
    for (int i = 1; i <= last; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_keys", 32'(bus.key_out), 32'hF);
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("abort_hold_done", 32'(bus.done), 32'd0);
          check("abort_hold_keys", 32'(bus.key_out), 32'hF);
        end
        rst_n = 1'b1;
        exp_keys = 4'hF;
        mlfsr = 16'hACE1;
        @(negedge clk);
        check("abort_post_ready", 32'(bus.cmd_ready), 32'd1);
        return;
      end
      lvl = start;
      if (!direct) begin
        foreach (tg[j])
          if (tg[j] <= i) lvl = ~lvl;
        if (i > BT) lvl = tgt;
      end
      want = exp_keys;
      want[k] = lvl;
      check($sformatf("keys@T+%0d", i), 32'(bus.key_out), 32'(want));
      check($sformatf("done@T+%0d", i), 32'(bus.done),
            32'(i == last - 1));
      check($sformatf("ready@T+%0d", i), 32'(bus.cmd_ready),
            32'(i == last));
      if (i <= BT && bus.key_out[k] !== prev) begin
        obs.push_back(i);
        prev = bus.key_out[k];
      end
      if (i == inj) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = 2'(inj_key);
        bus.cmd_press = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      if (i < last) @(negedge clk);
    end
    for (int j = 1; j < obs.size(); j++)
      check("gap_in_range",
            32'(obs[j] - obs[j-1] >= 1 && obs[j] - obs[j-1] <= GM),
            32'd1);
    if (!direct)
      check("first_toggle", 32'(obs.size() > 0 ? obs[0] : 0), 32'd1);
    exp_keys[k] = tgt;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_key   = 2'd0;
    bus.cmd_press = 1'b0;
    exp_keys = 4'hF;
    mlfsr = 16'hACE1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_keys", 32'(bus.key_out), 32'hF);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);

    // press key 2 with bounce
    send(2, 1'b1);
    watch(2, 1'b0, 0, 0, 0);

    // release key 0, already high: straight to settle
    send(0, 1'b0);
    watch(0, 1'b1, 0, 0, 0);

    // release key 2 while a key-1 press is offered mid-bounce
    send(2, 1'b0);
    watch(2, 1'b1, 5, 1, 0);

    // press key 3, reset at T+10
    send(3, 1'b1);
    watch(3, 1'b0, 0, 0, 10);

    // fresh press after the aborted command
    send(2, 1'b1);
    watch(2, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
